// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: sync marker default, FSM state
// encodings, frame field order and the running checksum step.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CNT_HI  = 4'd1,
    ST_CNT_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHECK   = 4'd6,
    ST_RUN     = 4'd7,
    ST_ERR     = 4'd8
  } loader_state_e;

  // Order in which fields arrive on the byte stream.
  typedef enum logic [2:0] {
    FLD_SYNC     = 3'd0,
    FLD_COUNT_HI = 3'd1,
    FLD_COUNT_LO = 3'd2,
    FLD_WORD_HI  = 3'd3,
    FLD_WORD_LO  = 3'd4,
    FLD_CSUM     = 3'd5
  } frame_field_e;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle counter for the loader: clears on request, otherwise counts up
// and flags the cycle on which it would reach TIMEOUT.
module loader_timeout_counter #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign expired = inc & ~clr & (count_q >= LAST);

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: writes a framed byte-stream image into instruction memory and
// holds the CPU in reset until the frame checksum matches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 65535,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        pc_reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_e state_q, state_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic        rx_ready_q, rx_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [15:0] imem_addr_q, imem_addr_d;
  logic [15:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept_s, tmo_active_s, tmo_expired_s;
  logic [15:0] n_rx_s, index_inc_s;

  assign accept_s     = rx_valid & rx_ready_q;
  assign tmo_active_s = state_q inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI,
                                       ST_DATA_LO, ST_WRITE, ST_CHECK};
  assign n_rx_s       = {nwords_q[15:8], rx_byte};
  assign index_inc_s  = index_q + 16'd1;

  loader_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (pc_reset_n),
    .clr     (accept_s | ~tmo_active_s),
    .inc     (tmo_active_s & ~accept_s),
    .expired (tmo_expired_s)
  );

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d      = state_q;
    nwords_d     = nwords_q;
    index_d      = index_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;

    if (tmo_expired_s) begin
      state_d = ST_ERR;
      error_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (accept_s && (rx_byte == SYNC_BYTE)) begin
            state_d     = ST_CNT_HI;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            csum_d      = 8'h00;
            index_d     = 16'd0;
          end else begin
            state_d = state_q;
          end
        end
        ST_CNT_HI: begin
          if (accept_s) begin
            nwords_d = {rx_byte, 8'h00};
            csum_d   = csum_next(csum_q, rx_byte);
            state_d  = ST_CNT_LO;
          end else begin
            state_d = state_q;
          end
        end
        ST_CNT_LO: begin
          if (accept_s) begin
            nwords_d = n_rx_s;
            csum_d   = csum_next(csum_q, rx_byte);
            if (n_rx_s == 16'd0) begin
              state_d = ST_CHECK;
            end else if ({1'b0, n_rx_s} > MAX_N) begin
              state_d = ST_ERR;
              error_d = 1'b1;
            end else begin
              state_d = ST_DATA_HI;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_DATA_HI: begin
          if (accept_s) begin
            hi_d    = rx_byte;
            csum_d  = csum_next(csum_q, rx_byte);
            state_d = ST_DATA_LO;
          end else begin
            state_d = state_q;
          end
        end
        ST_DATA_LO: begin
          // The strobe is registered, so it lands in the WRITE cycle itself.
          if (accept_s) begin
            csum_d       = csum_next(csum_q, rx_byte);
            imem_we_d    = 1'b1;
            imem_addr_d  = index_q;
            imem_wdata_d = {hi_q, rx_byte};
            state_d      = ST_WRITE;
          end else begin
            state_d = state_q;
          end
        end
        ST_WRITE: begin
          index_d = index_inc_s;
          if (index_inc_s == nwords_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_CHECK: begin
          if (accept_s) begin
            if (rx_byte == csum_q) begin
              state_d     = ST_RUN;
              cpu_reset_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              state_d = ST_ERR;
              error_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    rx_ready_d = (state_d != ST_WRITE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!pc_reset_n) begin
      state_q      <= ST_IDLE;
      nwords_q     <= 16'd0;
      index_q      <= 16'd0;
      hi_q         <= 8'h00;
      csum_q       <= 8'h00;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 16'd0;
      imem_wdata_q <= 16'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nwords_q     <= nwords_d;
      index_q      <= index_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
